// File: rtl/job_sequencer_if.sv
// Host, data RAM, engine and result RAM signals of the job sequencer.
// The master modport is the sequencer side; slave is the surrounding system.
interface job_sequencer_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          job_start;
    logic          job_ready;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    eng_ctrl;
    logic          eng_bsy;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          done;
    logic          err;

    modport master (
        input  job_start, in_valid, in_data, eng_bsy, res_rdata, out_ready,
        output job_ready, in_ready, mem_we, mem_addr, mem_wdata, eng_ctrl,
        output res_addr, out_valid, out_data, done, err
    );

    modport slave (
        output job_start, in_valid, in_data, eng_bsy, res_rdata, out_ready,
        input  job_ready, in_ready, mem_we, mem_addr, mem_wdata, eng_ctrl,
        input  res_addr, out_valid, out_data, done, err
    );
endinterface

// File: rtl/job_sequencer.sv
// Job sequencer for the 8-tap convolution engine: load samples,
// kick the engine, supervise its busy time, stream results to the host.
module job_sequencer #(
    parameter int DEPTH = 32,
    parameter int AW    = 6,
    parameter int DW    = 16,
    parameter int TMO   = 1023
) (
    input logic             clk,
    input logic             rst,
    job_sequencer_if.master bus
);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);
    localparam logic [TW-1:0] WMAX  = TW'(3);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT,
        S_RUN, S_ABORT, S_DRAIN, S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [TW-1:0] tmo_q;
    logic          rd_q;
    logic          job_ready_q;
    logic          in_ready_q;
    logic [1:0]    eng_ctrl_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          done_q;
    logic          err_q;
    logic          hs_in;
    logic          hs_out;

    assign hs_in  = in_ready_q & bus.in_valid;
    assign hs_out = out_valid_q & bus.out_ready;
    assign cnt_d  = cnt_q + CW'(1);

    assign bus.mem_we    = hs_in;
    assign bus.mem_addr  = cnt_q[AW-1:0];
    assign bus.mem_wdata = bus.in_data;
    assign bus.job_ready = job_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.eng_ctrl  = eng_ctrl_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // The next read is issued in the handshake cycle itself so its data
    // is ready one cycle later, giving one result every two cycles.
    assign bus.res_addr = (state_q == S_DRAIN)
                        ? cnt_q[AW-1:0] + AW'(hs_out)
                        : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            rd_q        <= 1'b0;
            job_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            eng_ctrl_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.job_start) begin
                        state_q     <= S_CLEAR;
                        job_ready_q <= 1'b0;
                        err_q       <= 1'b0;
                        eng_ctrl_q  <= 2'b10;
                    end
                end
                S_CLEAR: begin
                    state_q    <= S_LOAD;
                    eng_ctrl_q <= 2'b00;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                end
                S_LOAD: begin
                    if (hs_in) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST) begin
                            state_q    <= S_START;
                            in_ready_q <= 1'b0;
                            eng_ctrl_q <= 2'b01;
                        end
                    end
                end
                S_START: begin
                    state_q    <= S_WAIT;
                    eng_ctrl_q <= 2'b00;
                    tmo_q      <= '0;
                end
                S_WAIT: begin
                    if (bus.eng_bsy) begin
                        state_q <= S_RUN;
                        tmo_q   <= '0;
                    end else if (tmo_q == WMAX) begin
                        state_q    <= S_ABORT;
                        err_q      <= 1'b1;
                        eng_ctrl_q <= 2'b10;
                        done_q     <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!bus.eng_bsy) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                        rd_q    <= 1'b0;
                    end else if (tmo_q == TMO_V) begin
                        state_q    <= S_ABORT;
                        err_q      <= 1'b1;
                        eng_ctrl_q <= 2'b10;
                        done_q     <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_ABORT: begin
                    state_q     <= S_IDLE;
                    eng_ctrl_q  <= 2'b00;
                    done_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                end
                S_DRAIN: begin
                    if (out_valid_q) begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            if (cnt_q == LAST) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_d;
                                rd_q  <= 1'b1;
                            end
                        end
                    end else if (rd_q) begin
                        out_data_q  <= bus.res_rdata;
                        out_valid_q <= 1'b1;
                        rd_q        <= 1'b0;
                    end else begin
                        rd_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_job_sequencer.sv
// Randomised scoreboard bench for job_sequencer with behavioural
// data RAM, result RAM and convolution engine models.
module tb_job_sequencer;
    localparam int DEPTH = 32;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int TMO   = 1023;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    job_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    job_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TMO(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dmem [64];
    logic [DW-1:0] rmem [64];
    logic [DW-1:0] coef [8];
    wr_t           wq [$];
    logic [DW-1:0] rq [$];

    int done_cnt, clr_cnt, start_cnt, viol;
    int cyc = 0;
    int start_cyc, done_cyc;
    int eng_mode = 0;
    int eng_b = 0;
    bit bp_en = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: y[i] = sum_k coef[k] * x[i-k], truncated to DW bits
    function automatic logic [DW-1:0] ref_conv(
        input logic [DW-1:0] x [DEPTH], input int i);
        logic [DW-1:0] acc = '0;
        for (int k = 0; k < 8; k++)
            if (i - k >= 0) acc = acc + coef[k] * x[i-k];
        return acc;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
        bus.res_rdata <= rmem[bus.res_addr];
    end

    // Engine: after a start pulse, rise busy 0..2 cycles later, hold
    // for eng_b cycles, then publish results from the data RAM.
    initial begin
        bus.eng_bsy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_ctrl == 2'b01 && eng_mode != 2) begin
                int d;
                logic [DW-1:0] acc;
                d = (eng_mode == 1) ? 0 : $urandom_range(0, 2);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1 bus.eng_bsy = 1'b1;
                repeat (eng_b) @(posedge clk);
                #1;
                for (int i = 0; i < DEPTH; i++) begin
                    acc = '0;
                    for (int k = 0; k < 8; k++)
                        if (i - k >= 0) acc = acc + coef[k] * dmem[i-k];
                    rmem[i] = acc;
                end
                bus.eng_bsy = 1'b0;
            end
        end
    end

    int burst = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                bus.out_ready = 1'b1;
            end else if (burst > 0) begin
                bus.out_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.out_ready = 1'b0;
                burst = 4;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.eng_ctrl == 2'b10) clr_cnt++;
            if (bus.eng_ctrl == 2'b11) viol++;
            if (bus.eng_ctrl == 2'b01) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid && bus.in_ready) viol++;
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(bus.mem_addr), 32'hFFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", 32'(bus.mem_addr), 32'(w.addr));
                    chk("write_data", 32'(bus.mem_wdata), 32'(w.data));
                end
            end
            if (hold && (!bus.out_valid || bus.out_data !== hold_data))
                viol++;
            hold      = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (rq.size() == 0)
                    chk("unexpected_result", 32'(bus.out_data), 32'hFFFFF);
                else
                    chk("result", 32'(bus.out_data), 32'(rq.pop_front()));
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(bus.job_ready === 1'b1 && bus.eng_bsy == 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        done_cnt  = 0;
        clr_cnt   = 0;
        start_cnt = 0;
        viol      = 0;
    endtask

    task automatic issue_start();
        bus.job_start = 1'b1;
        @(posedge clk);
        #1 bus.job_start = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(bus.err), 0);
        chk("job_ready_busy", 32'(bus.job_ready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int idx, input logic [DW-1:0] v, input bit gaps);
        int n = 0;
        logic acc;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        wq.push_back('{addr: AW'(idx), data: v});
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("load_timeout", 32'(n), 0);
    endtask

    task automatic run_job(input int mode, input int b, input bit ramp,
                           input bit gaps, input bit exp_err);
        logic [DW-1:0] x [DEPTH];
        int n = 0;
        wait_idle();
        eng_mode = mode;
        eng_b    = b;
        for (int i = 0; i < DEPTH; i++)
            x[i] = ramp ? DW'(i) : DW'($urandom);
        if (mode == 0)
            for (int i = 0; i < DEPTH; i++) rq.push_back(ref_conv(x, i));
        issue_start();
        for (int i = 0; i < DEPTH; i++) feed(i, x[i], gaps);
        bus.in_valid = 1'b0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 32'(n), 0);
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("clear_pulses", 32'(clr_cnt), (mode == 0) ? 1 : 2);
        chk("start_pulses", 32'(start_cnt), 1);
        chk("err_flag", 32'(bus.err), 32'(exp_err));
        chk("job_ready_end", 32'(bus.job_ready), 1);
        chk("results_left", 32'(rq.size()), 0);
        chk("writes_left", 32'(wq.size()), 0);
        chk("protocol_violations", 32'(viol), 0);
        if (mode == 2) chk("dead_abort_time", 32'(done_cyc - start_cyc), 5);
        if (mode == 1)
            chk("stuck_abort_time", 32'(done_cyc - start_cyc), TMO + 3);
        rq.delete();
        wq.delete();
    endtask

    initial begin
        coef[0] = 16'd3;  coef[1] = 16'd1;  coef[2] = 16'hFFFE; coef[3] = 16'd5;
        coef[4] = 16'd7;  coef[5] = 16'd2;  coef[6] = 16'hFFFF; coef[7] = 16'd4;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = '0;
            rmem[i] = '0;
        end
        bus.job_start = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_job_ready", 32'(bus.job_ready), 1);
        chk("rst_eng_ctrl", 32'(bus.eng_ctrl), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_done", 32'(bus.done), 0);

        run_job(0, 260, 1'b1, 1'b0, 1'b0);

        bp_en = 1'b1;
        for (int j = 0; j < 3; j++)
            run_job(0, $urandom_range(4, 60), 1'b0, 1'b1, 1'b0);
        bp_en = 1'b0;

        run_job(1, 1100, 1'b0, 1'b0, 1'b1);
        run_job(0, $urandom_range(4, 60), 1'b0, 1'b0, 1'b0);
        run_job(2, 0, 1'b0, 1'b0, 1'b1);
        run_job(0, $urandom_range(4, 60), 1'b0, 1'b1, 1'b0);

        wait_idle();
        eng_mode = 0;
        eng_b    = 20;
        issue_start();
        for (int i = 0; i < 10; i++) feed(i, DW'($urandom), 1'b0);
        chk("reset_pre_writes_left", 32'(wq.size()), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_job_ready", 32'(bus.job_ready), 1);
        chk("midrst_mem_we", 32'(bus.mem_we), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_eng_ctrl", 32'(bus.eng_ctrl), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        wq.delete();
        run_job(0, $urandom_range(4, 60), 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
